// File: rtl/calc_ctrl.sv
// calc_ctrl: calculator control stage downstream of the keypad scanner.
// It turns held key levels into single key events, with a release
// debounce of REL_CYC low cycles. It accumulates up to four decimal
// digits per operand and runs add/subtract on '='. The signed result is
// converted to five BCD digits by a 15-cycle sequential double-dabble.
//
// Optional feature (macro CALC_CHAIN_EN): an add/sub key in S_RES
// carries a non-negative, non-overflowed result into operand A and
// continues in S_B. Without the macro that key is ignored in S_RES.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   btn_press  key-active level from the scanner
//   is_num     held key is a digit (value on num_val, 0-9)
//   is_op      held key is an operator (op_val: 1=add 2=sub 3=clear)
//   is_eq      held key is '='
//   disp_bcd   four BCD display digits, [15:12] most significant
//   disp_neg   displayed result is negative
//   disp_ovf   result magnitude exceeds 9999
//   busy       BCD conversion in progress
//   state_o    0=S_A 1=S_B 2=S_CONV 3=S_RES
module calc_ctrl #(
  parameter int REL_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_press,
  input  logic        is_num,
  input  logic        is_op,
  input  logic        is_eq,
  input  logic [3:0]  num_val,
  input  logic [1:0]  op_val,
  output logic [15:0] disp_bcd,
  output logic        disp_neg,
  output logic        disp_ovf,
  output logic        busy,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_CONV = 2'd2, S_RES = 2'd3} state_t;

  localparam logic [7:0] REL_M1 = 8'(REL_CYC - 1);

  state_t      state, state_nxt;
  logic        armed;
  logic [7:0]  rel_cnt;
  logic [13:0] a_bin, b_bin;
  logic [15:0] a_bcd, b_bcd;
  logic [2:0]  a_cnt, b_cnt;
  logic        op_sub, neg;
  logic [3:0]  conv_cnt;
  // Double-dabble register: [34:15] five BCD digits, [14:0] binary.
  logic [34:0] dd;
`ifdef CALC_CHAIN_EN
  logic [14:0] res_bin;
`endif

  logic        ev, ev_eq, ev_op, ev_num;
  logic        dig_ev, arith_ev, clr_ev, res_ovf, a_ge_b, neg_new;
  logic [14:0] mag;

  function automatic logic [13:0] mul10_add(input logic [13:0] bin, input logic [3:0] d);
    return (bin << 3) + (bin << 1) + {10'd0, d};
  endfunction

  function automatic logic [34:0] dd_step(input logic [34:0] x);
    logic [34:0] y;
    y = x;
    for (int i = 0; i < 5; i++) begin
      if (y[15+4*i +: 4] >= 4'd5) y[15+4*i +: 4] = y[15+4*i +: 4] + 4'd3;
    end
    return {y[33:0], 1'b0};
  endfunction

  function automatic logic [2:0] sig_digits(input logic [15:0] bcd);
    if (bcd[15:12] != 4'd0)     return 3'd4;
    else if (bcd[11:8] != 4'd0) return 3'd3;
    else if (bcd[7:4] != 4'd0)  return 3'd2;
    else if (bcd[3:0] != 4'd0)  return 3'd1;
    else                        return 3'd0;
  endfunction

  // One event per accepted press; flags decoded with eq > op > num priority.
  assign ev       = btn_press & armed;
  assign ev_eq    = ev & is_eq;
  assign ev_op    = ev & ~is_eq & is_op;
  assign ev_num   = ev & ~is_eq & ~is_op & is_num;
  assign dig_ev   = ev_num & (num_val <= 4'd9);
  assign arith_ev = ev_op & ((op_val == 2'd1) | (op_val == 2'd2));
  assign clr_ev   = ev_op & (op_val == 2'd3) & (state != S_CONV);
  assign res_ovf  = (dd[34:31] != 4'd0);

  assign a_ge_b  = (a_bin >= b_bin);
  assign neg_new = op_sub & ~a_ge_b;
  always_comb begin
    mag = {1'b0, a_bin} + {1'b0, b_bin};
    if (op_sub) mag = a_ge_b ? ({1'b0, a_bin} - {1'b0, b_bin})
                             : ({1'b0, b_bin} - {1'b0, a_bin});
  end

  // Release debounce: re-arm after REL_CYC consecutive low cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed   <= 1'b1;
      rel_cnt <= 8'd0;
    end else if (btn_press) begin
      rel_cnt <= 8'd0;
      if (armed) armed <= 1'b0;
    end else begin
      if (rel_cnt != 8'hFF) rel_cnt <= rel_cnt + 8'd1;
      if (rel_cnt >= REL_M1) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_A;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_A:    if (clr_ev) state_nxt = S_A;
              else if (arith_ev) state_nxt = S_B;
      S_B:    if (ev_eq) state_nxt = S_CONV;
              else if (clr_ev) state_nxt = S_A;
      S_CONV: if (conv_cnt == 4'd15) state_nxt = S_RES;
      S_RES: begin
        if (clr_ev || dig_ev) state_nxt = S_A;
`ifdef CALC_CHAIN_EN
        else if (arith_ev && !neg && !res_ovf) state_nxt = S_B;
`endif
      end
      default: state_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_bin    <= '0;
      a_bcd    <= '0;
      a_cnt    <= '0;
      b_bin    <= '0;
      b_bcd    <= '0;
      b_cnt    <= '0;
      op_sub   <= 1'b0;
      neg      <= 1'b0;
      conv_cnt <= '0;
      dd       <= '0;
`ifdef CALC_CHAIN_EN
      res_bin  <= '0;
`endif
    end else if (clr_ev) begin
      a_bin  <= '0;
      a_bcd  <= '0;
      a_cnt  <= '0;
      b_bin  <= '0;
      b_bcd  <= '0;
      b_cnt  <= '0;
      op_sub <= 1'b0;
      neg    <= 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (dig_ev && a_cnt < 3'd4) begin
            a_bin <= mul10_add(a_bin, num_val);
            a_bcd <= {a_bcd[11:0], num_val};
            a_cnt <= a_cnt + 3'd1;
          end else if (arith_ev) begin
            op_sub <= (op_val == 2'd2);
            b_bin  <= '0;
            b_bcd  <= '0;
            b_cnt  <= '0;
          end
        end
        S_B: begin
          if (ev_eq) begin
            dd       <= {20'd0, mag};
            neg      <= neg_new;
            conv_cnt <= 4'd0;
`ifdef CALC_CHAIN_EN
            res_bin  <= mag;
`endif
          end else if (dig_ev && b_cnt < 3'd4) begin
            b_bin <= mul10_add(b_bin, num_val);
            b_bcd <= {b_bcd[11:0], num_val};
            b_cnt <= b_cnt + 3'd1;
          end else if (arith_ev) begin
            op_sub <= (op_val == 2'd2);
          end
        end
        S_CONV: begin
          if (conv_cnt != 4'd15) begin
            dd       <= dd_step(dd);
            conv_cnt <= conv_cnt + 4'd1;
          end
        end
        S_RES: begin
          if (dig_ev) begin
            a_bin <= {10'd0, num_val};
            a_bcd <= {12'd0, num_val};
            a_cnt <= 3'd1;
            neg   <= 1'b0;
          end
`ifdef CALC_CHAIN_EN
          else if (arith_ev && !neg && !res_ovf) begin
            a_bin  <= res_bin[13:0];
            a_bcd  <= dd[30:15];
            a_cnt  <= sig_digits(dd[30:15]);
            op_sub <= (op_val == 2'd2);
            b_bin  <= '0;
            b_bcd  <= '0;
            b_cnt  <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // During conversion the last operand stays on the display.
  always_comb begin
    disp_bcd = 16'h0000;
    case (state)
      S_A:     disp_bcd = a_bcd;
      S_B:     disp_bcd = b_bcd;
      S_CONV:  disp_bcd = b_bcd;
      S_RES:   disp_bcd = dd[30:15];
      default: disp_bcd = 16'h0000;
    endcase
  end

  assign disp_neg = (state == S_RES) & neg;
  assign disp_ovf = (state == S_RES) & res_ovf;
  assign busy     = (state == S_CONV);
  assign state_o  = state;

`ifndef CALC_CHAIN_EN
  logic unused_sig;
  assign unused_sig = ^sig_digits(dd[30:15]);
`endif

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_press = 1'b0;
  logic        is_num = 1'b0;
  logic        is_op = 1'b0;
  logic        is_eq = 1'b0;
  logic [3:0]  num_val = 4'd0;
  logic [1:0]  op_val = 2'd0;
  logic [15:0] disp_bcd;
  logic        disp_neg;
  logic        disp_ovf;
  logic        busy;
  logic [1:0]  state_o;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  calc_ctrl #(.REL_CYC(4)) dut (
    .clk(clk), .rst(rst), .btn_press(btn_press), .is_num(is_num),
    .is_op(is_op), .is_eq(is_eq), .num_val(num_val), .op_val(op_val),
    .disp_bcd(disp_bcd), .disp_neg(disp_neg), .disp_ovf(disp_ovf),
    .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key(input logic n, input logic o, input logic e,
                     input logic [3:0] nv, input logic [1:0] ov);
    @(negedge clk);
    btn_press = 1'b1; is_num = n; is_op = o; is_eq = e; num_val = nv; op_val = ov;
    @(negedge clk);
    btn_press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] d);
    key(1'b1, 1'b0, 1'b0, d, 2'd0);
  endtask

  task automatic opk(input logic [1:0] o);
    key(1'b0, 1'b1, 1'b0, 4'd0, o);
  endtask

  // Press '=' and push the expected result; pop and compare once conversion ends.
  task automatic equals(input logic [15:0] e_bcd, input logic e_neg, input logic e_ovf);
    int   busy_cnt;
    int   cyc;
    exp_t e;
    sb.push_back('{bcd: e_bcd, neg: e_neg, ovf: e_ovf});
    @(negedge clk);
    btn_press = 1'b1; is_eq = 1'b1;
    @(negedge clk);
    btn_press = 1'b0; is_eq = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    while (busy && cyc < 100) begin
      busy_cnt++;
      cyc++;
      @(negedge clk);
    end
    chk("busy_len", busy_cnt, 16);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_bcd", {16'd0, disp_bcd}, {16'd0, e.bcd});
      chk("res_neg", {31'd0, disp_neg}, {31'd0, e.neg});
      chk("res_ovf", {31'd0, disp_ovf}, {31'd0, e.ovf});
      chk("res_state", {30'd0, state_o}, 32'd3);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bcd", {16'd0, disp_bcd}, 32'd0);
    chk("rst_neg", {31'd0, disp_neg}, 32'd0);
    chk("rst_ovf", {31'd0, disp_ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 12 + 34
    digit(4'd1);
    digit(4'd2);
    chk("a_12", {16'd0, disp_bcd}, 32'h0012);
    opk(2'd1);
    chk("sb_state", {30'd0, state_o}, 32'd1);
    chk("sb_blank", {16'd0, disp_bcd}, 32'h0000);
    digit(4'd3);
    digit(4'd4);
    chk("b_34", {16'd0, disp_bcd}, 32'h0034);
    equals(16'h0046, 1'b0, 1'b0);

    // 5 - 12
    opk(2'd3);
    chk("clr_state", {30'd0, state_o}, 32'd0);
    digit(4'd5); opk(2'd2); digit(4'd1); digit(4'd2);
    equals(16'h0007, 1'b1, 1'b0);

    // 42 - 42
    opk(2'd3);
    digit(4'd4); digit(4'd2); opk(2'd2); digit(4'd4); digit(4'd2);
    equals(16'h0000, 1'b0, 1'b0);

    // 9999 + 9999
    opk(2'd3);
    for (int i = 0; i < 4; i++) digit(4'd9);
    opk(2'd1);
    for (int i = 0; i < 4; i++) digit(4'd9);
    equals(16'h9998, 1'b0, 1'b1);

    // invalid digit and '=' in S_A are ignored
    opk(2'd3);
    digit(4'd12);
    chk("dig_gt9", {16'd0, disp_bcd}, 32'h0000);
    key(1'b0, 1'b0, 1'b1, 4'd0, 2'd0);
    chk("eq_in_a", {30'd0, state_o}, 32'd0);

    // held key with short release gap yields one digit
    @(negedge clk);
    btn_press = 1'b1; is_num = 1'b1; num_val = 4'd7;
    repeat (50) @(negedge clk);
    btn_press = 1'b0;
    repeat (2) @(negedge clk);
    btn_press = 1'b1;
    repeat (10) @(negedge clk);
    btn_press = 1'b0; is_num = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_7", {16'd0, disp_bcd}, 32'h0007);

    // five digits: the fifth is dropped
    opk(2'd3);
    for (int i = 1; i <= 5; i++) digit(4'(i));
    chk("five_dig", {16'd0, disp_bcd}, 32'h1234);

    // chaining from S_RES
    opk(2'd3);
    digit(4'd2); opk(2'd1); digit(4'd3);
    equals(16'h0005, 1'b0, 1'b0);
    opk(2'd1);
`ifdef CALC_CHAIN_EN
    chk("chain_state", {30'd0, state_o}, 32'd1);
    digit(4'd4);
    equals(16'h0009, 1'b0, 1'b0);
`else
    chk("nochain_state", {30'd0, state_o}, 32'd3);
    chk("nochain_bcd", {16'd0, disp_bcd}, 32'h0005);
`endif

    // reset during conversion
    opk(2'd3);
    digit(4'd1); opk(2'd1); digit(4'd1);
    @(negedge clk);
    btn_press = 1'b1; is_eq = 1'b1;
    @(negedge clk);
    btn_press = 1'b0; is_eq = 1'b0;
    repeat (4) @(negedge clk);
    chk("conv_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_bcd", {16'd0, disp_bcd}, 32'h0000);
    chk("abort_state", {30'd0, state_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // clear from S_B
    digit(4'd3); opk(2'd1); digit(4'd8);
    chk("b_8", {16'd0, disp_bcd}, 32'h0008);
    opk(2'd3);
    chk("clr_b_state", {30'd0, state_o}, 32'd0);
    chk("clr_b_bcd", {16'd0, disp_bcd}, 32'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
